// File: rtl/cim_pkg.sv
// Shared types and elaboration-time helpers for the CIM GeMM macro.
// Latency: n/a (types, constant functions and a combinational clamp).
// Backpressure: n/a.
package cim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } cim_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Accumulator width: product bits plus input precision plus growth from
  // summing n_in terms, plus one bit of headroom for the signed MSB term.
  function automatic int acc_width(input int data_w, input int in_prec, input int n_in);
    return data_w + in_prec + clog2(n_in) + 1;
  endfunction

  // Clamp a 64-bit signed value into an out_w-bit unsigned or two's
  // complement range. The caller keeps the low out_w bits of the result.
  function automatic logic [63:0] sat_clamp(input logic signed [63:0] x,
                                            input int out_w,
                                            input bit is_signed);
    longint hi;
    longint lo;
    if (is_signed) begin
      hi = (longint'(1) <<< (out_w - 1)) - 1;
      lo = -(longint'(1) <<< (out_w - 1));
    end else begin
      hi = (longint'(1) << out_w) - 1;
      lo = 0;
    end
    if (x > hi) begin
      return 64'(hi);
    end else if (x < lo) begin
      return 64'(lo);
    end
    return 64'(x);
  endfunction

endpackage

// File: rtl/cim_adc_sat.sv
// ADC model for one output channel: right shift then saturate.
// Latency: combinational; the top registers the result on DONE.
// Backpressure: none.
// Ports:
//   acc_in  - raw accumulator of one output channel
//   sat_out - shifted and clamped ADC code
module cim_adc_sat
  import cim_pkg::*;
#(
  parameter int ACC_W         = 19,
  parameter int ADC_PRECISION = 8,
  parameter int ADC_SHIFT     = 8,
  parameter int SIGNED        = 0
) (
  input  logic [ACC_W-1:0]         acc_in,
  output logic [ADC_PRECISION-1:0] sat_out
);

  logic signed [63:0] acc_ext;
  logic signed [63:0] shifted;

  always_comb begin
    if (SIGNED != 0) begin
      // Two's complement accumulator: sign-extend and shift arithmetically.
      acc_ext = 64'(signed'(acc_in));
      shifted = acc_ext >>> ADC_SHIFT;
    end else begin
      // Unsigned accumulator: zero-extend, logical shift.
      acc_ext = 64'(acc_in);
      shifted = acc_ext >> ADC_SHIFT;
    end
    sat_out = ADC_PRECISION'(sat_clamp(shifted, ADC_PRECISION, SIGNED != 0));
  end

endmodule

// File: rtl/cim_gemm_macro.sv
// Bit-serial compute-in-memory GeMM macro with a plain SRAM mode.
// Latency: SRAM read 1 cycle; CIM result IN_PREC+1 cycles after start.
// Backpressure: none; every command is dropped while cim_busy is high.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   a, cs, web      - word address / tile base, chip select, write enable (low)
//   cimeb, d        - CIM enable (low), write data
//   cim_in          - N_IN inputs of IN_PREC bits, channel i at [i*IN_PREC +: IN_PREC]
//   q               - registered read data
//   cim_out         - N_OUT ADC codes, channel j at [j*ADC_PRECISION +: ADC_PRECISION]
//   cim_busy        - computation in progress
//   cim_valid       - one-cycle pulse when cim_out is updated
module cim_gemm_macro
  import cim_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int N_IN          = 4,
  parameter int N_OUT         = 8,
  parameter int IN_PREC       = 8,
  parameter int ADC_PRECISION = 8,
  parameter int ADC_SHIFT     = 8,
  parameter int SIGNED        = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          a,
  input  logic                           cs,
  input  logic                           web,
  input  logic                           cimeb,
  input  logic [DATA_WIDTH-1:0]          d,
  input  logic [N_IN*IN_PREC-1:0]        cim_in,
  output logic [DATA_WIDTH-1:0]          q,
  output logic [N_OUT*ADC_PRECISION-1:0] cim_out,
  output logic                           cim_busy,
  output logic                           cim_valid
);

  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int TILE_WORDS = N_IN * N_OUT;
  localparam int TILE_BITS  = clog2(TILE_WORDS);
  localparam int TILE_IDX_W = ADDR_WIDTH - TILE_BITS;
  localparam int ACC_W      = acc_width(DATA_WIDTH, IN_PREC, N_IN);
  localparam int K_W        = (clog2(IN_PREC) > 0) ? clog2(IN_PREC) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(IN_PREC - 1);

  // Weight storage; deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  cim_state_e                           state_q, state_d;
  logic [K_W-1:0]                       k_q, k_d;
  logic [TILE_IDX_W-1:0]                tile_q, tile_d;
  logic [N_IN-1:0][IN_PREC-1:0]         in_q, in_d;
  logic [N_OUT-1:0][ACC_W-1:0]          acc_q, acc_d;
  logic [DATA_WIDTH-1:0]                q_q, q_d;
  logic [N_OUT-1:0][ADC_PRECISION-1:0]  cim_out_q, cim_out_d;
  logic                                 cim_valid_q, cim_valid_d;

  logic                                 mem_we;
  logic [N_OUT-1:0][ACC_W-1:0]          partial;
  logic [N_OUT-1:0][ADC_PRECISION-1:0]  sat_res;
  logic [DATA_WIDTH-1:0]                w_word;
  logic [ACC_W-1:0]                     w_ext;

  // Column sums for the current input bit: every column j adds the weights
  // of the rows whose input has bit k set. All N_IN*N_OUT words of the
  // latched tile are read in parallel, which is the CIM array's job.
  always_comb begin
    partial = '0;
    w_word  = '0;
    w_ext   = '0;
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        w_word = mem[{tile_q, TILE_BITS'(i * N_OUT + j)}];
        if (SIGNED != 0) begin
          w_ext = ACC_W'(signed'(w_word));
        end else begin
          w_ext = ACC_W'(w_word);
        end
        if (in_q[i][k_q]) begin
          partial[j] = partial[j] + w_ext;
        end
      end
    end
  end

  // Next-state and command decode. Commands are only looked at in IDLE.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    tile_d      = tile_q;
    in_d        = in_q;
    acc_d       = acc_q;
    q_d         = q_q;
    cim_out_d   = cim_out_q;
    cim_valid_d = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs) begin
          if (!web) begin
            mem_we = 1'b1;
          end else if (cimeb) begin
            q_d = mem[a];
          end else begin
            in_d    = cim_in;
            tile_d  = a[ADDR_WIDTH-1 -: TILE_IDX_W];
            acc_d   = '0;
            k_d     = '0;
            state_d = ST_COMPUTE;
          end
        end
      end

      ST_COMPUTE: begin
        for (int j = 0; j < N_OUT; j++) begin
          // In two's complement the input MSB carries negative weight.
          if ((SIGNED != 0) && (k_q == K_LAST)) begin
            acc_d[j] = acc_q[j] - (partial[j] << k_q);
          end else begin
            acc_d[j] = acc_q[j] + (partial[j] << k_q);
          end
        end
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end

      ST_DONE: begin
        cim_out_d   = sat_res;
        cim_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  for (genvar gj = 0; gj < N_OUT; gj++) begin : g_adc
    cim_adc_sat #(
      .ACC_W         (ACC_W),
      .ADC_PRECISION (ADC_PRECISION),
      .ADC_SHIFT     (ADC_SHIFT),
      .SIGNED        (SIGNED)
    ) u_adc (
      .acc_in  (acc_q[gj]),
      .sat_out (sat_res[gj])
    );
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[a] <= d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      tile_q      <= '0;
      in_q        <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      cim_out_q   <= '0;
      cim_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      tile_q      <= tile_d;
      in_q        <= in_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      cim_out_q   <= cim_out_d;
      cim_valid_q <= cim_valid_d;
    end
  end

  assign q         = q_q;
  assign cim_out   = cim_out_q;
  assign cim_busy  = (state_q != ST_IDLE);
  assign cim_valid = cim_valid_q;

endmodule

// File: tb/tb_cim_gemm_macro.sv
// Scoreboard bench for cim_gemm_macro: default instance plus a signed,
// unshifted instance. Drivers push expected q / cim_out words into queues;
// a negedge monitor pops and compares whenever a read lands or valid pulses.
module tb_cim_gemm_macro;

  logic        clk = 1'b0;
  logic        rst;

  logic [9:0]  a, s_a;
  logic        cs, web, cimeb, s_cs, s_web, s_cimeb;
  logic [7:0]  d, s_d;
  logic [31:0] cim_in, s_cim_in;
  logic [7:0]  q, s_q;
  logic [63:0] cim_out, s_cim_out;
  logic        cim_busy, cim_valid, s_busy, s_valid;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_out_q[$];
  logic [63:0] exp_rd_q[$];
  logic [63:0] exp_sout_q[$];
  bit          rd_pend = 1'b0;

  always #5 clk = ~clk;

  cim_gemm_macro u_dut (
    .clk(clk), .rst(rst), .a(a), .cs(cs), .web(web), .cimeb(cimeb), .d(d),
    .cim_in(cim_in), .q(q), .cim_out(cim_out), .cim_busy(cim_busy),
    .cim_valid(cim_valid)
  );

  cim_gemm_macro #(.SIGNED(1), .ADC_SHIFT(0)) u_sdut (
    .clk(clk), .rst(rst), .a(s_a), .cs(s_cs), .web(s_web), .cimeb(s_cimeb),
    .d(s_d), .cim_in(s_cim_in), .q(s_q), .cim_out(s_cim_out),
    .cim_busy(s_busy), .cim_valid(s_valid)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: output with no expectation queued", name);
  endtask

  // Monitor: inputs are stable at negedge, so a read seen here with the DUT
  // idle is accepted at the next posedge and its data shows at the negedge after.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rd_pend) begin
      if (exp_rd_q.size() == 0) unexpected("q_read");
      else begin
        e = exp_rd_q.pop_front();
        chk("q_read", 64'(q), e);
      end
    end
    rd_pend = cs && web && cimeb && !cim_busy && !rst;
    if (cim_valid) begin
      if (exp_out_q.size() == 0) unexpected("cim_valid");
      else begin
        e = exp_out_q.pop_front();
        chk("cim_out", cim_out, e);
      end
    end
    if (s_valid) begin
      if (exp_sout_q.size() == 0) unexpected("s_cim_valid");
      else begin
        e = exp_sout_q.pop_front();
        chk("s_cim_out", s_cim_out, e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = 1'b0; web = 1'b1; cimeb = 1'b1;
    s_cs = 1'b0; s_web = 1'b1; s_cimeb = 1'b1;
  endtask

  task automatic wr(input logic [9:0] addr, input logic [7:0] data);
    a = addr; d = data; cs = 1'b1; web = 1'b0; cimeb = 1'b1;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [9:0] addr, input logic [7:0] exp);
    exp_rd_q.push_back(64'(exp));
    a = addr; cs = 1'b1; web = 1'b1; cimeb = 1'b1;
    cyc();
    idle();
  endtask

  task automatic start(input logic [9:0] addr, input logic [31:0] vec);
    a = addr; cim_in = vec; cs = 1'b1; web = 1'b1; cimeb = 1'b0;
    cyc();
    idle();
  endtask

  task automatic s_wr(input logic [9:0] addr, input logic [7:0] data);
    s_a = addr; s_d = data; s_cs = 1'b1; s_web = 1'b0; s_cimeb = 1'b1;
    cyc();
    idle();
  endtask

  task automatic s_start(input logic [9:0] addr, input logic [31:0] vec);
    s_a = addr; s_cim_in = vec; s_cs = 1'b1; s_web = 1'b1; s_cimeb = 1'b0;
    cyc();
    idle();
  endtask

  // Bounded wait for all queued expectations to be consumed.
  task automatic wait_drain(input string name);
    for (int n = 0; n < 40; n++) begin
      if ((exp_out_q.size() + exp_rd_q.size() + exp_sout_q.size()) == 0) break;
      cyc();
    end
    chk(name, 64'(exp_out_q.size() + exp_rd_q.size() + exp_sout_q.size()), 64'd0);
    repeat (2) cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic busy_at_last;

    idle();
    a = '0; d = '0; cim_in = '0;
    s_a = '0; s_d = '0; s_cim_in = '0;
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;

    // Reset state
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_cim_out", cim_out, 64'd0);
    chk("rst_busy", 64'(cim_busy), 64'd0);
    chk("rst_valid", 64'(cim_valid), 64'd0);
    chk("rst_s_cim_out", s_cim_out, 64'd0);

    // SRAM: write then read the same address on the very next cycle
    wr(10'h123, 8'h5A);
    rd(10'h123, 8'h5A);
    chk("sram_busy", 64'(cim_busy), 64'd0);
    wait_drain("drain_sram");
    repeat (3) cyc();
    chk("q_hold", 64'(q), 64'h5A);

    // Unsigned dot product: W=1, inputs 255 -> 1020>>8 = 3 per channel
    for (int i = 0; i < 32; i++) wr(10'(i), 8'h01);
    exp_out_q.push_back(64'h0303030303030303);
    start(10'd0, 32'hFFFF_FFFF);
    chk("dot_busy_e0", 64'(cim_busy), 64'd1);
    lat = 0;
    busy_at_last = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (n == 8) busy_at_last = cim_busy;
      if (cim_valid) begin
        lat = n;
        break;
      end
    end
    chk("dot_latency", 64'(lat), 64'd9);
    chk("dot_busy_e8", 64'(busy_at_last), 64'd1);
    chk("dot_busy_e9", 64'(cim_busy), 64'd0);
    cyc();
    chk("dot_valid_one_cycle", 64'(cim_valid), 64'd0);
    wait_drain("drain_dot");

    // Saturation: W=255, inputs 255 -> 260100>>8 = 1016 -> 255.
    // A start presented on the DONE edge must be dropped.
    for (int i = 0; i < 32; i++) wr(10'(i), 8'hFF);
    exp_out_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    start(10'd0, 32'hFFFF_FFFF);
    repeat (8) cyc();
    a = 10'd0; cim_in = 32'h0101_0101; cs = 1'b1; web = 1'b1; cimeb = 1'b0;
    cyc();
    idle();
    chk("sat_start_at_done_ignored", 64'(cim_busy), 64'd0);
    repeat (12) cyc();
    chk("sat_no_second_run", 64'(cim_busy), 64'd0);
    wait_drain("drain_sat");

    // Signed, no shift: in0 = 0x80 (-128), W00 = -1, W01 = 1
    s_wr(10'd0, 8'hFF);
    s_wr(10'd1, 8'h01);
    for (int j = 2; j < 8; j++) s_wr(10'(j), 8'h00);
    exp_sout_q.push_back(64'h0000_0000_0000_807F);
    s_start(10'd0, 32'h0000_0080);
    wait_drain("drain_signed");

    // Tile addressing and command blocking while busy
    for (int i = 0; i < 32; i++) wr(10'(i), 8'h00);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) wr(10'(32 + i * 8 + j), 8'(j));
    exp_out_q.push_back(64'h0101_0101_0000_0000);
    start(10'd32, 32'h1010_1010);
    wr(10'd0, 8'hEE);
    start(10'd0, 32'hFFFF_FFFF);
    a = 10'd33; cs = 1'b1; web = 1'b1; cimeb = 1'b1;
    cyc();
    idle();
    chk("busy_still_high", 64'(cim_busy), 64'd1);
    chk("q_hold_busy", 64'(q), 64'h5A);
    wait_drain("drain_tile");
    repeat (12) cyc();
    rd(10'd0, 8'h00);
    rd(10'd33, 8'h01);
    wait_drain("drain_tile_rd");

    // Reset in the middle of COMPUTE
    start(10'd32, 32'hFFFF_FFFF);
    repeat (4) cyc();
    rst = 1'b1;
    #1;
    chk("midrst_q", 64'(q), 64'd0);
    chk("midrst_cim_out", cim_out, 64'd0);
    chk("midrst_busy", 64'(cim_busy), 64'd0);
    chk("midrst_valid", 64'(cim_valid), 64'd0);
    cyc();
    rst = 1'b0;
    repeat (15) cyc();
    chk("midrst_idle", 64'(cim_busy), 64'd0);
    // 1020*j >> 8 per channel; memory survives reset
    exp_out_q.push_back(64'h1B17_130F_0B07_0300);
    start(10'd32, 32'hFFFF_FFFF);
    wait_drain("drain_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
